pipe_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with carry-in, carry-out, signed overflow, optional saturation and a sticky overflow flag. It succeeds the fixed 16-bit combinational adder. The carry chain is split into `STAGES` registered segments so wide operands close timing. A valid/ready handshake on both sides lets it sit directly in streaming datapaths.

---
 rtl/pipe_addsub_if.sv | 14 +
 rtl/pipe_addsub.sv | 92 +++++++++
 tb/tb_pipe_addsub.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pipe_addsub_if.sv
// pipe_addsub_if: operand/result stream for pipe_addsub, valid/ready on both sides
interface pipe_addsub_if #(parameter int WIDTH = 16);
    logic             in_valid, in_ready, cin, sub, sat;
    logic             out_valid, out_ready, cout, overflow, ovf_sticky, clr_sticky;
    logic [WIDTH-1:0] a, b, sum;
    modport master (
        output in_valid, a, b, cin, sub, sat, out_ready, clr_sticky,
        input  in_ready, out_valid, sum, cout, overflow, ovf_sticky
    );
    modport slave (
        input  in_valid, a, b, cin, sub, sat, out_ready, clr_sticky,
        output in_ready, out_valid, sum, cout, overflow, ovf_sticky
    );
endinterface

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined add/sub with carry chain split into STAGES segments.
// Optional saturation on signed overflow when PIPE_ADDSUB_SAT_EN is defined.
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input logic        clk,
    input logic        rst,
    pipe_addsub_if.slave io
);
    localparam int SEG = WIDTH / STAGES;
    localparam int L   = STAGES - 1;
    logic             vld [STAGES];
    logic             rc  [STAGES];
    logic [WIDTH-1:0] ra  [STAGES];
    logic [WIDTH-1:0] rb  [STAGES];
    logic [WIDTH-1:0] rs  [STAGES];
    logic [WIDTH-1:0] be;
    logic             ce, stall, ovf, sticky;
`ifdef PIPE_ADDSUB_SAT_EN
    logic             rsat [STAGES];
`else
    logic             unused_sat;
    assign unused_sat = io.sat;
`endif
    assign be          = io.sub ? ~io.b : io.b;
    assign ce          = io.sub ^ io.cin;
    assign stall       = vld[L] && !io.out_ready;
    assign io.in_ready = !stall && !rst;
    // stage 0 consumes the live operands; later stages read the previous register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld[0] <= 1'b0;
            rc[0]  <= 1'b0;
            ra[0]  <= '0;
            rb[0]  <= '0;
            rs[0]  <= '0;
`ifdef PIPE_ADDSUB_SAT_EN
            rsat[0] <= 1'b0;
`endif
        end else if (!stall) begin
            vld[0] <= io.in_valid && io.in_ready;
            ra[0]  <= io.a;
            rb[0]  <= be;
            rs[0]  <= '0;
            {rc[0], rs[0][SEG-1:0]} <= {1'b0, io.a[SEG-1:0]} + {1'b0, be[SEG-1:0]} + (SEG+1)'(ce);
`ifdef PIPE_ADDSUB_SAT_EN
            rsat[0] <= io.sat;
`endif
        end
    end
    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld[k] <= 1'b0;
                rc[k]  <= 1'b0;
                ra[k]  <= '0;
                rb[k]  <= '0;
                rs[k]  <= '0;
`ifdef PIPE_ADDSUB_SAT_EN
                rsat[k] <= 1'b0;
`endif
            end else if (!stall) begin
                vld[k] <= vld[k-1];
                ra[k]  <= ra[k-1];
                rb[k]  <= rb[k-1];
                rs[k]  <= rs[k-1];
                {rc[k], rs[k][k*SEG +: SEG]} <= {1'b0, ra[k-1][k*SEG +: SEG]}
                                              + {1'b0, rb[k-1][k*SEG +: SEG]} + (SEG+1)'(rc[k-1]);
`ifdef PIPE_ADDSUB_SAT_EN
                rsat[k] <= rsat[k-1];
`endif
            end
        end
    end
    assign ovf = (ra[L][WIDTH-1] == rb[L][WIDTH-1]) && (rs[L][WIDTH-1] != ra[L][WIDTH-1]);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sticky <= 1'b0;
        else if (vld[L] && io.out_ready && ovf) sticky <= 1'b1;
        else if (io.clr_sticky) sticky <= 1'b0;
    end
    assign io.out_valid  = vld[L];
    assign io.cout       = rc[L];
    assign io.overflow   = ovf;
    assign io.ovf_sticky = sticky;
`ifdef PIPE_ADDSUB_SAT_EN
    // clamp toward the sign of a: positive overflow -> 0x7F..F, negative -> 0x80..0
    assign io.sum = (rsat[L] && ovf) ? {ra[L][WIDTH-1], {(WIDTH-1){~ra[L][WIDTH-1]}}} : rs[L];
`else
    assign io.sum = rs[L];
`endif
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed vectors for pipe_addsub (WIDTH 16, STAGES 2)
module tb_pipe_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
`ifdef PIPE_ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    pipe_addsub_if #(.WIDTH(16)) io ();
    pipe_addsub #(.WIDTH(16), .STAGES(2)) dut (.clk(clk), .rst(rst), .io(io));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub, input logic sat,
                      input logic [15:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        io.a = a; io.b = b; io.cin = cin; io.sub = sub; io.sat = sat; io.in_valid = 1'b1;
        @(posedge clk);
        #1 io.in_valid = 1'b0;
        n = 1;
        while (!io.out_valid && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_lat"}, n, 2);
        check({tag, "_sum"}, io.sum, es);
        check({tag, "_cout"}, io.cout, ec);
        check({tag, "_ovf"}, io.overflow, eo);
    endtask
    initial begin
        logic [15:0] got[$];
        int n;
        io.in_valid = 1'b0; io.a = '0; io.b = '0; io.cin = 1'b0; io.sub = 1'b0; io.sat = 1'b0;
        io.out_ready = 1'b1; io.clr_sticky = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", io.in_ready, 0);
        check("rst_out_valid", io.out_valid, 0);
        check("rst_sum", io.sum, 0);
        check("rst_cout", io.cout, 0);
        check("rst_ovf", io.overflow, 0);
        check("rst_sticky", io.ovf_sticky, 0);
        rst = 1'b0;
        #1 check("rel_in_ready", io.in_ready, 1);
        op("add_ovf", 16'h7FFF, 16'h7FFF, 0, 0, 1, SAT ? 16'h7FFF : 16'hFFFE, 0, 1);
        @(posedge clk);
        #1 check("sticky_set", io.ovf_sticky, 1);
        op("add_neg", 16'h8000, 16'h8000, 0, 0, 1, SAT ? 16'h8000 : 16'h0000, 1, 1);
        op("carry_in", 16'hFFFF, 16'h0001, 1, 0, 0, 16'h0001, 1, 0);
        op("seg_carry", 16'h00FF, 16'h0001, 0, 0, 0, 16'h0100, 0, 0);
        op("pos_ovf", 16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 0, 1);
        op("sub_neg", 16'h0005, 16'h0007, 0, 1, 0, 16'hFFFE, 0, 0);
        op("sub_ovf", 16'h8000, 16'h0001, 0, 1, 0, 16'h7FFF, 1, 1);
        op("sub_borrow", 16'h000A, 16'h0003, 1, 1, 0, 16'h0006, 1, 0);
        @(negedge clk);
        io.clr_sticky = 1'b1;
        @(posedge clk);
        #1 io.clr_sticky = 1'b0;
        check("sticky_clr", io.ovf_sticky, 0);
        @(negedge clk);
        io.out_ready = 1'b0; io.sub = 1'b0; io.cin = 1'b0; io.sat = 1'b0;
        io.a = 16'd1; io.b = 16'd1; io.in_valid = 1'b1;
        @(negedge clk);
        io.a = 16'd2; io.b = 16'd2;
        @(negedge clk);
        io.a = 16'd3; io.b = 16'd3;
        check("stall_in_ready", io.in_ready, 0);
        check("stall_valid", io.out_valid, 1);
        check("stall_sum", io.sum, 16'h0002);
        repeat (3) begin
            @(negedge clk);
            check("stall_hold", io.sum, 16'h0002);
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        #1 io.in_valid = 1'b0;
        for (int i = 0; i < 10 && got.size() < 2; i++) begin
            @(negedge clk);
            if (io.out_valid) got.push_back(io.sum);
        end
        check("drain_count", got.size(), 2);
        if (got.size() == 2) begin
            check("drain_1", got[0], 16'h0004);
            check("drain_2", got[1], 16'h0006);
        end
        @(negedge clk);
        io.out_ready = 1'b0; io.a = 16'h7FFF; io.b = 16'h0001; io.in_valid = 1'b1;
        @(posedge clk);
        #1 io.in_valid = 1'b0;
        n = 0;
        while (!io.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("win_valid", io.out_valid, 1);
        check("win_pre", io.ovf_sticky, 0);
        @(negedge clk);
        io.out_ready = 1'b1; io.clr_sticky = 1'b1;
        @(posedge clk);
        #1 io.clr_sticky = 1'b0;
        check("set_wins", io.ovf_sticky, 1);
        @(negedge clk);
        io.a = 16'h7FFF; io.b = 16'h7FFF; io.in_valid = 1'b1;
        @(negedge clk);
        io.a = 16'h0001; io.b = 16'h0002;
        @(posedge clk);
        #1 io.in_valid = 1'b0;
        rst = 1'b1;
        #1 check("arst_valid", io.out_valid, 0);
        check("arst_sticky", io.ovf_sticky, 0);
        check("arst_in_ready", io.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("no_stale", io.out_valid, 0);
        end
        op("post_rst", 16'h1234, 16'h1111, 0, 0, 0, 16'h2345, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
